// File: rtl/leb128_pkg.sv
// Shared constants and FSM state type for the LEB128 u32 encoder family.
package leb128_pkg;

    localparam int DATA_W        = 32;
    localparam int CHUNK_W       = 7;
    localparam int U32_MAX_BYTES = 5;
    localparam int CNT_W         = 3;
    localparam int BYTE_W        = 8;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

endpackage

// File: rtl/leb128_last.sv
// Final-byte detector: decides whether the current chunk ends the value.
// Signed (sign-fill) termination when LEB128_SIGNED_EN is defined, unsigned otherwise.
module leb128_last
    import leb128_pkg::*;
(
    input  logic [DATA_W-1:0] shift_i,
    input  logic [CNT_W-1:0]  cnt_i,
    output logic              last_o
);

    logic rem_done;
    logic max_cnt;

    assign max_cnt = (cnt_i == CNT_W'(U32_MAX_BYTES - 1));

`ifdef LEB128_SIGNED_EN
    logic signed [DATA_W-1:0] rem;

    // Done once the remainder is pure sign extension of the chunk's top bit.
    assign rem      = $signed(shift_i) >>> CHUNK_W;
    assign rem_done = (rem == {DATA_W{shift_i[CHUNK_W-1]}});
`else
    assign rem_done = (shift_i[DATA_W-1:CHUNK_W] == '0);
`endif

    assign last_o = rem_done | max_cnt;

endmodule

// File: rtl/leb128_enc_u32.sv
// Streaming LEB128 encoder for 32-bit values, one byte per output transfer.
// Define LEB128_SIGNED_EN to encode int32 as signed LEB128 instead of unsigned.
module leb128_enc_u32
    import leb128_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              i_ready,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic              o_last
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                last_w;
    logic                in_xfer;
    logic                out_xfer;
    logic [DATA_W-1:0]   shift_next;

    leb128_last u_last (
        .shift_i (shift_q),
        .cnt_i   (cnt_q),
        .last_o  (last_w)
    );

`ifdef LEB128_SIGNED_EN
    assign shift_next = $signed(shift_q) >>> CHUNK_W;
`else
    assign shift_next = shift_q >> CHUNK_W;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        o_valid  = 1'b0;
        o_last   = 1'b0;
        i_ready  = 1'b0;
        o_data   = '0;
        in_xfer  = 1'b0;
        out_xfer = 1'b0;

        case (state_q)
            IDLE: begin
                i_ready = 1'b1;
            end
            EMIT: begin
                o_valid = 1'b1;
                o_last  = last_w;
                // Accepting the next value on the final byte removes the idle bubble.
                i_ready = last_w & o_ready;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        o_data   = {~o_last, shift_q[CHUNK_W-1:0]};
        in_xfer  = i_valid & i_ready;
        out_xfer = o_valid & o_ready;

        if (in_xfer) begin
            shift_d = i_data;
            cnt_d   = '0;
            state_d = EMIT;
        end else if (out_xfer) begin
            if (o_last) begin
                state_d = IDLE;
            end else begin
                shift_d = shift_next;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
